// File: rtl/rv_pkg.sv
// Shared types for the load/store path: access size, initiator FSM state,
// and the request legality / offset-alignment helpers.
package rv_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    MI_IDLE,
    MI_RD,
    MI_WR,
    MI_RSP
  } mi_state_t;

  // Size 11 is never legal; alignment only matters when checking is enabled.
  function automatic logic req_legal(input logic [1:0] size, input logic [1:0] off,
                                     input logic align_check);
    case (size)
      2'b00:   req_legal = 1'b1;
      2'b01:   req_legal = !align_check || !off[0];
      2'b10:   req_legal = !align_check || (off == 2'b00);
      default: req_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b01:   align_off = {off[1], 1'b0};
      2'b10:   align_off = 2'b00;
      default: align_off = off;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane.sv
// Byte-lane datapath: little-endian load extract with sign/zero extension,
// and sub-word store merge into a full 32-bit word.
module mem_lane
  import rv_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  mem_size_t   i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [31:0] w_shifted;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    w_shifted = i_word >> {i_off, 3'b000};
    o_load    = w_shifted;
    o_merged  = i_wdata;
    case (i_size)
      SZ_B: begin
        o_load = {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
        o_merged = i_word;
        o_merged[{i_off, 3'b000} +: 8] = i_wdata[7:0];
      end
      SZ_H: begin
        o_load = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
        o_merged = i_word;
        o_merged[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_initiator.sv
// Shared-bus load/store initiator: request handshake, read / read-modify-write
// sequencing, and tristate ownership of addr and bus while a transfer is in flight.
module mem_initiator
  import rv_pkg::*;
#(
  parameter int READ_LAT    = 1,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  inout  wire  [31:0] addr,
  inout  wire  [31:0] bus,
  output logic        mem_read,
  output logic        mem_write
);

  localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  mi_state_t   r_state, w_next;
  logic        r_write, r_unsigned, r_err;
  mem_size_t   r_size;
  logic [1:0]  r_off;
  logic [31:0] r_addr, r_wdata, r_word;
  logic [CW-1:0] r_cnt;
  logic        w_rd_last, w_legal, w_addr_en, w_bus_en;
  logic [31:0] w_load, w_merged;

  assign w_rd_last = (r_cnt == CW'(READ_LAT - 1));
  assign w_legal   = req_legal(req_size, req_addr[1:0], ALIGN_CHECK);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= MI_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      MI_IDLE: if (req_valid) begin
        if (!w_legal)                               w_next = MI_RSP;
        else if (req_write && req_size == 2'b10)    w_next = MI_WR;
        else                                        w_next = MI_RD;
      end
      MI_RD:   if (w_rd_last) w_next = r_write ? MI_WR : MI_RSP;
      MI_WR:   w_next = MI_RSP;
      default: w_next = MI_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_write    <= 1'b0;
      r_unsigned <= 1'b0;
      r_err      <= 1'b0;
      r_size     <= SZ_B;
      r_off      <= 2'b00;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_word     <= '0;
      r_cnt      <= '0;
    end else begin
      if (r_state == MI_IDLE && req_valid) begin
        r_write    <= req_write;
        r_unsigned <= req_unsigned;
        r_err      <= !w_legal;
        r_size     <= mem_size_t'(req_size);
        r_off      <= align_off(req_size, req_addr[1:0]);
        r_addr     <= {req_addr[31:2], 2'b00};
        r_wdata    <= req_wdata;
      end
      r_cnt <= (r_state == MI_RD) ? r_cnt + 1'b1 : '0;
      if (r_state == MI_RD && w_rd_last) r_word <= bus;
    end
  end

  mem_lane u_lane (
    .i_word     (r_word),
    .i_off      (r_off),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_wdata    (r_wdata),
    .o_load     (w_load),
    .o_merged   (w_merged)
  );

  // Strobes and bus enables decode from registered state, so reset drops them at once.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    w_addr_en = 1'b0;
    w_bus_en  = 1'b0;
    case (r_state)
      MI_IDLE: req_ready = rst;
      MI_RD: begin
        mem_read  = 1'b1;
        w_addr_en = 1'b1;
      end
      MI_WR: begin
        mem_write = 1'b1;
        w_addr_en = 1'b1;
        w_bus_en  = 1'b1;
      end
      default: begin
        rsp_valid = 1'b1;
        rsp_err   = r_err;
        rsp_rdata = (r_err || r_write) ? 32'h0 : w_load;
      end
    endcase
  end

  assign addr = w_addr_en ? r_addr   : 'z;
  assign bus  = w_bus_en  ? w_merged : 'z;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench: mem_initiator against a behavioural shared-bus word memory.
module tb_mem_initiator;

  localparam int P_READ_LAT = 3;
  localparam int P_B2B_CYC  = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, mem_read, mem_write;
  logic [31:0] rsp_rdata;
  wire  [31:0] addr, bus;

  logic [31:0] mem [0:1023];

  int n_tests = 0, n_fail = 0;
  int rd_cycles = 0, wr_cycles = 0, overlap = 0, accepts = 0, rsps = 0;

  always #5 clk = ~clk;

  mem_initiator #(.READ_LAT(P_READ_LAT), .ALIGN_CHECK(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .addr         (addr),
    .bus          (bus),
    .mem_read     (mem_read),
    .mem_write    (mem_write)
  );

  // Responder: combinational read while mem_read, word write on the clock edge.
  assign bus = mem_read ? mem[addr[11:2]] : 'z;
  always @(posedge clk) if (mem_write) mem[addr[11:2]] <= bus;

  always @(negedge clk) begin
    if (mem_read)              rd_cycles++;
    if (mem_write)             wr_cycles++;
    if (mem_read && mem_write) overlap++;
  end

  always @(posedge clk) begin
    if (req_valid && req_ready) accepts++;
    if (rsp_valid)              rsps++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request, then wait (bounded) for its response and check everything observed.
  task automatic run(input string tag, input logic w, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                     input logic exp_err, input int exp_lat, input int exp_rdc, input int exp_wrc);
    int guard, lat, rd0, wr0;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_ready"}, 32'(req_ready), 32'h1);
    req_write = w; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    rd0 = rd_cycles; wr0 = wr_cycles;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = 32'hA5A5_A5A7; req_wdata = ~wd; req_size = 2'b11;
    req_write = ~w; req_unsigned = ~uns;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 40);
    check({tag, "_rdata"}, rsp_rdata, exp_rd);
    check({tag, "_err"},   32'(rsp_err), 32'(exp_err));
    check({tag, "_lat"},   32'(lat), 32'(exp_lat));
    check({tag, "_rdcyc"}, 32'(rd_cycles - rd0), 32'(exp_rdc));
    check({tag, "_wrcyc"}, 32'(wr_cycles - wr0), 32'(exp_wrc));
  endtask

  localparam int L = P_READ_LAT;

  initial begin
    int acc0, rsp0, exp_b2b;
    repeat (3) @(negedge clk);
    check("rst_ready",  32'(req_ready), 32'h0);
    check("rst_rvalid", 32'(rsp_valid), 32'h0);
    check("rst_rerr",   32'(rsp_err),   32'h0);
    check("rst_rdata",  rsp_rdata,      32'h0);
    check("rst_mrd",    32'(mem_read),  32'h0);
    check("rst_mwr",    32'(mem_write), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'h1);

    //   tag      w     sz     uns   addr           wdata          exp_rd         err  lat  rdc wrc
    run("sw100",  1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         1'b0, 2,   0, 1);
    run("lw100",  1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1'b0, L+1, L, 0);
    run("sw200",  1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'h8081_7F80, 32'h0,         1'b0, 2,   0, 1);
    run("lb203",  1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0,         32'hFFFF_FF80, 1'b0, L+1, L, 0);
    run("lbu201", 1'b0, 2'b00, 1'b1, 32'h0000_0201, 32'h0,         32'h0000_007F, 1'b0, L+1, L, 0);
    run("lb201",  1'b0, 2'b00, 1'b0, 32'h0000_0201, 32'h0,         32'h0000_007F, 1'b0, L+1, L, 0);
    run("lbu203", 1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'h0,         32'h0000_0080, 1'b0, L+1, L, 0);
    run("lh202",  1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0,         32'hFFFF_8081, 1'b0, L+1, L, 0);
    run("lhu200", 1'b0, 2'b01, 1'b1, 32'h0000_0200, 32'h0,         32'h0000_7F80, 1'b0, L+1, L, 0);
    run("lh200",  1'b0, 2'b01, 1'b0, 32'h0000_0200, 32'h0,         32'h0000_7F80, 1'b0, L+1, L, 0);

    run("sw300",  1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'h1122_3344, 32'h0,         1'b0, 2,   0, 1);
    run("sb301",  1'b1, 2'b00, 1'b0, 32'h0000_0301, 32'hFFFF_FFAA, 32'h0,         1'b0, L+2, L, 1);
    check("mem300_sb", mem[32'h300 >> 2], 32'h1122_AA44);
    run("sh302",  1'b1, 2'b01, 1'b0, 32'h0000_0302, 32'h1234_BEEF, 32'h0,         1'b0, L+2, L, 1);
    check("mem300_sh", mem[32'h300 >> 2], 32'hBEEF_AA44);
    run("lbu303", 1'b0, 2'b00, 1'b1, 32'h0000_0303, 32'h0,         32'h0000_00BE, 1'b0, L+1, L, 0);

    run("lh101",  1'b0, 2'b01, 1'b0, 32'h0000_0101, 32'h0,         32'h0,         1'b1, 1,   0, 0);
    run("lw102",  1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0,         32'h0,         1'b1, 1,   0, 0);
    run("sz11",   1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0,         32'h0,         1'b1, 1,   0, 0);
    run("sh303",  1'b1, 2'b01, 1'b0, 32'h0000_0303, 32'h0000_1234, 32'h0,         1'b1, 1,   0, 0);
    check("mem300_err", mem[32'h300 >> 2], 32'hBEEF_AA44);

    run("swtop",  1'b1, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0BAD_F00D, 32'h0,         1'b0, 2,   0, 1);
    run("lwtop",  1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0BAD_F00D, 1'b0, L+1, L, 0);
    run("lw100b", 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1'b0, L+1, L, 0);

    // Reset in the read phase of a byte store must abort it before the write.
    run("sw400",  1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'h5566_7788, 32'h0,         1'b0, 2,   0, 1);
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0000_0401; req_wdata = 32'h0000_0099; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort_in_rd", 32'(mem_read), 32'h1);
    rst = 1'b0;
    #1;
    check("abort_mrd",   32'(mem_read),  32'h0);
    check("abort_mwr",   32'(mem_write), 32'h0);
    check("abort_ready", 32'(req_ready), 32'h0);
    check("abort_rvld",  32'(rsp_valid), 32'h0);
    repeat (2) @(negedge clk);
    check("abort_hold_mwr", 32'(mem_write), 32'h0);
    rst = 1'b1;
    #1;
    check("abort_rel_ready", 32'(req_ready), 32'h1);
    repeat (L + 3) @(negedge clk);
    check("abort_mem400", mem[32'h400 >> 2], 32'h5566_7788);
    run("lw400",  1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0,         32'h5566_7788, 1'b0, L+1, L, 0);

    // Back-to-back loads with req_valid held high.
    @(negedge clk);
    acc0 = accepts; rsp0 = rsps;
    exp_b2b = (P_B2B_CYC + L + 1) / (L + 2);
    req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h0000_0100; req_valid = 1'b1;
    repeat (P_B2B_CYC) @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (L + 4) @(negedge clk);
    check("b2b_accepts", 32'(accepts - acc0), 32'(exp_b2b));
    check("b2b_rsps",    32'(rsps - rsp0),    32'(exp_b2b));
    check("no_overlap",  32'(overlap),        32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
